// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and types for the fetch/decode hazard controller.
package pipe_ctrl_pkg;

    // PCSrcE encodings driven by the Execute stage
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RSVD   = 2'b11;

    // ResultSrcE value that marks a load in Execute
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        TRAP = 2'b10
    } fhc_state_t;

    // A load in E whose destination feeds an operand of the instruction in D.
    // x0 is never a real dependency.
    function automatic logic load_use_hit(input logic [1:0] result_src,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return (result_src == RESULTSRC_LOAD) && (rd != 5'd0) &&
               ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Fetch/decode control interface between the pipeline datapath and the
// hazard controller. The datapath is the master, the controller the slave.
interface fetch_hazard_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    // Execute / Decode information towards the controller
    logic [1:0]            PCSrcE_i;
    logic [DATA_WIDTH-1:0] PCTargetE_i;
    logic [DATA_WIDTH-1:0] ALUResultE_i;
    logic                  JalrE_i;
    logic [1:0]            ResultSrcE_i;
    logic [4:0]            RdE_i;
    logic [4:0]            Rs1D_i;
    logic [4:0]            Rs2D_i;

    // Fetch PC and pipeline register controls back to the datapath
    logic [DATA_WIDTH-1:0] PCF_o;
    logic [DATA_WIDTH-1:0] PCPlus4F_o;
    logic                  Fen_o;
    logic                  Frst_o;
    logic                  Den_o;
    logic                  Drst_o;
    logic                  Trap_o;
    logic [15:0]           StallCnt_o;
    logic [15:0]           FlushCnt_o;

    modport master (
        output PCSrcE_i, PCTargetE_i, ALUResultE_i, JalrE_i,
               ResultSrcE_i, RdE_i, Rs1D_i, Rs2D_i,
        input  PCF_o, PCPlus4F_o, Fen_o, Frst_o, Den_o, Drst_o,
               Trap_o, StallCnt_o, FlushCnt_o
    );

    modport slave (
        input  PCSrcE_i, PCTargetE_i, ALUResultE_i, JalrE_i,
               ResultSrcE_i, RdE_i, Rs1D_i, Rs2D_i,
        output PCF_o, PCPlus4F_o, Fen_o, Frst_o, Den_o, Drst_o,
               Trap_o, StallCnt_o, FlushCnt_o
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment on each event until the counter is full
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch PC owner and stall/flush generator for the F/D and D/E registers:
// boot hold, redirect flush, load-use stall, misaligned-redirect trap.
module fetch_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    BOOT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_hazard_ctrl_if.slave bus
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    fhc_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [BOOT_W-1:0]     boot_cnt_q, boot_cnt_d;

    logic [DATA_WIDTH-1:0] redirect_tgt;
    logic                  redirect;
    logic                  redirect_bad;
    logic                  load_use;
    logic                  fen, frst, den, drst;
    logic                  flush_inc, stall_inc;

    // Decode the Execute-stage redirect and the load-use dependency
    always_comb begin
        redirect = (bus.PCSrcE_i != PCSRC_SEQ);
        if ((bus.PCSrcE_i == PCSRC_JUMP) && bus.JalrE_i) begin
            redirect_tgt = {bus.ALUResultE_i[DATA_WIDTH-1:1], 1'b0};
        end else begin
            redirect_tgt = bus.PCTargetE_i;
        end
        redirect_bad = (bus.PCSrcE_i == PCSRC_RSVD) || (redirect_tgt[1:0] != 2'b00);
        load_use     = load_use_hit(bus.ResultSrcE_i, bus.RdE_i, bus.Rs1D_i, bus.Rs2D_i);
    end

    // State register plus PC and boot counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    // Next state, next PC and boot window progress
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end
            RUN: begin
                if (redirect) begin
                    if (redirect_bad) begin
                        state_d = TRAP;
                    end else begin
                        pc_d = redirect_tgt;
                    end
                end else if (!load_use) begin
                    pc_d = pc_q + DATA_WIDTH'(4);
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Mealy enable/flush controls and counter events
    always_comb begin
        fen       = 1'b0;
        frst      = 1'b0;
        den       = 1'b0;
        drst      = 1'b1;
        flush_inc = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            BOOT: begin
                frst = 1'b1;
            end
            RUN: begin
                if (redirect) begin
                    // A faulting redirect squashes like TRAP; a good one flushes both stages
                    if (!redirect_bad) begin
                        fen       = 1'b1;
                        den       = 1'b1;
                        frst      = 1'b1;
                        flush_inc = 1'b1;
                    end
                end else if (load_use) begin
                    den       = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    fen  = 1'b1;
                    den  = 1'b1;
                    drst = 1'b0;
                end
            end
            default: begin
                // TRAP holds fetch and keeps bubbling into Execute
            end
        endcase
    end

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (bus.StallCnt_o)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (bus.FlushCnt_o)
    );

    assign bus.PCF_o      = pc_q;
    assign bus.PCPlus4F_o = pc_q + DATA_WIDTH'(4);
    assign bus.Fen_o      = fen;
    assign bus.Frst_o     = frst;
    assign bus.Den_o      = den;
    assign bus.Drst_o     = drst;
    assign bus.Trap_o     = (state_q == TRAP);

endmodule
